// File: rtl/tournament_selector.sv
// tournament_selector
//
// Parent-selection stage of the GA datapath. Draws random candidates from the
// population memory, runs two back-to-back fitness tournaments (dad, then mom),
// and presents the winning pair to the crossover stage under valid/ready.
// The pair is held stable until the consumer accepts it.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   ce             start request (sampled in IDLE and at the HOLD handshake)
//   random         random population index from the external generator
//   rand_ce        advances the random generator (every FETCH cycle)
//   mem_addr       population read address (= random during FETCH, else 0)
//   mem_re         population read enable; data returns one cycle later
//   mem_individual read data: chromosome
//   mem_fitness    read data: unsigned fitness
//   dad / mom      winners of the first / second tournament
//   dad_index      population address of dad
//   mom_index      population address of mom
//   out_valid      pair available
//   out_ready      consumer accepts the pair
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for ce; no reads issued
// FETCH | 2*T cycles: one random address issued per cycle
// DRAIN | last candidate's data is evaluated; no read issued
// HOLD  | pair presented with out_valid; leaves on handshake

module tournament_selector #(
  parameter int IndividualWidth = 32,
  parameter int FitnessWidth    = 16,
  parameter int PopulationSize  = 16,
  parameter int AddrWidth       = $clog2(PopulationSize),
  parameter int TournamentSize  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [AddrWidth-1:0]       random,
  output logic                       rand_ce,
  output logic [AddrWidth-1:0]       mem_addr,
  output logic                       mem_re,
  input  logic [IndividualWidth-1:0] mem_individual,
  input  logic [FitnessWidth-1:0]    mem_fitness,
  output logic [IndividualWidth-1:0] dad,
  output logic [IndividualWidth-1:0] mom,
  output logic [AddrWidth-1:0]       dad_index,
  output logic [AddrWidth-1:0]       mom_index,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int NumCand  = 2 * TournamentSize;
  localparam int CntWidth = $clog2(NumCand);

  // cand_cnt counts down from NumCand-1 to 0, so a candidate's position is
  // identified by its count value rather than an index:
  //   CntLoad     first dad candidate
  //   CntDadLast  last dad candidate (equals CntLoad when T=1)
  //   CntMomFirst first mom candidate
  //   0           last mom candidate
  localparam logic [CntWidth-1:0] CntLoad     = CntWidth'(NumCand - 1);
  localparam logic [CntWidth-1:0] CntDadLast  = CntWidth'(TournamentSize);
  localparam logic [CntWidth-1:0] CntMomFirst = CntWidth'(TournamentSize - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e                state_q,     state_d;
  logic [CntWidth-1:0]   cand_cnt_q,  cand_cnt_d;
  logic                  out_valid_q, out_valid_d;

  // Tracks the read in flight: valid flag, candidate position, issued address.
  logic                  eval_vld_q,  eval_vld_d;
  logic [CntWidth-1:0]   eval_cnt_q,  eval_cnt_d;
  logic [AddrWidth-1:0]  eval_addr_q, eval_addr_d;

  logic [FitnessWidth-1:0]    best_fit_q, best_fit_d;
  logic [IndividualWidth-1:0] best_ind_q, best_ind_d;
  logic [AddrWidth-1:0]       best_idx_q, best_idx_d;

  logic [IndividualWidth-1:0] dad_q,     dad_d;
  logic [IndividualWidth-1:0] mom_q,     mom_d;
  logic [AddrWidth-1:0]       dad_idx_q, dad_idx_d;
  logic [AddrWidth-1:0]       mom_idx_q, mom_idx_d;

  logic                       first_cand;
  logic                       take_new;
  logic [FitnessWidth-1:0]    win_fit;
  logic [IndividualWidth-1:0] win_ind;
  logic [AddrWidth-1:0]       win_idx;

  // Control FSM: next state, read issue and candidate tracking.
  always_comb begin
    state_d     = state_q;
    cand_cnt_d  = cand_cnt_q;
    out_valid_d = out_valid_q;
    eval_vld_d  = 1'b0;
    eval_cnt_d  = eval_cnt_q;
    eval_addr_d = eval_addr_q;
    mem_re      = 1'b0;
    rand_ce     = 1'b0;
    mem_addr    = '0;

    case (state_q)
      S_IDLE: begin
        if (ce) begin
          state_d    = S_FETCH;
          cand_cnt_d = CntLoad;
        end
      end

      S_FETCH: begin
        mem_re      = 1'b1;
        rand_ce     = 1'b1;
        mem_addr    = random;
        eval_vld_d  = 1'b1;
        eval_cnt_d  = cand_cnt_q;
        eval_addr_d = random;
        if (cand_cnt_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          cand_cnt_d = cand_cnt_q - 1'b1;
        end
      end

      S_DRAIN: begin
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
      end

      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (ce) begin
            state_d    = S_FETCH;
            cand_cnt_d = CntLoad;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tournament evaluation on the returning read data. The first candidate of
  // each tournament loads unconditionally; later ones must be strictly fitter,
  // so ties keep the earlier candidate.
  always_comb begin
    first_cand = (eval_cnt_q == CntLoad) || (eval_cnt_q == CntMomFirst);
    take_new   = first_cand || (mem_fitness > best_fit_q);
    win_fit    = take_new ? mem_fitness    : best_fit_q;
    win_ind    = take_new ? mem_individual : best_ind_q;
    win_idx    = take_new ? eval_addr_q    : best_idx_q;

    best_fit_d = best_fit_q;
    best_ind_d = best_ind_q;
    best_idx_d = best_idx_q;
    dad_d      = dad_q;
    mom_d      = mom_q;
    dad_idx_d  = dad_idx_q;
    mom_idx_d  = mom_idx_q;

    if (eval_vld_q) begin
      best_fit_d = win_fit;
      best_ind_d = win_ind;
      best_idx_d = win_idx;
      if (eval_cnt_q == CntDadLast) begin
        dad_d     = win_ind;
        dad_idx_d = win_idx;
      end
      if (eval_cnt_q == '0) begin
        mom_d     = win_ind;
        mom_idx_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cand_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      eval_vld_q  <= 1'b0;
      eval_cnt_q  <= '0;
      eval_addr_q <= '0;
      best_fit_q  <= '0;
      best_ind_q  <= '0;
      best_idx_q  <= '0;
      dad_q       <= '0;
      mom_q       <= '0;
      dad_idx_q   <= '0;
      mom_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cand_cnt_q  <= cand_cnt_d;
      out_valid_q <= out_valid_d;
      eval_vld_q  <= eval_vld_d;
      eval_cnt_q  <= eval_cnt_d;
      eval_addr_q <= eval_addr_d;
      best_fit_q  <= best_fit_d;
      best_ind_q  <= best_ind_d;
      best_idx_q  <= best_idx_d;
      dad_q       <= dad_d;
      mom_q       <= mom_d;
      dad_idx_q   <= dad_idx_d;
      mom_idx_q   <= mom_idx_d;
    end
  end

  assign dad       = dad_q;
  assign mom       = mom_q;
  assign dad_index = dad_idx_q;
  assign mom_index = mom_idx_q;
  assign out_valid = out_valid_q;

endmodule
